// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the MEM stage and the cache.
// The master side issues dc_req/dc_we/dc_addr/dc_wdata; the slave answers with dc_rdata/dc_ack.
interface mem_access_unit_if;
    logic        dc_req;
    logic [3:0]  dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata;
    logic        dc_ack;

    modport master (
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_rdata, dc_ack
    );

    modport slave (
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_rdata, dc_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// EX/MEM stage register plus IDLE/REQ/DONE data-cache access FSM with wait timeout.
// Optional macro MEM_MISALIGN_CHECK_EN turns misaligned LH/LHU/SH/LW/SW into an immediate error.
module mem_access_unit #(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bubbleM,
    input  logic                   flushM,
    input  logic [31:0]            ALU_out_EX,
    input  logic [31:0]            store_data_EX,
    input  logic [3:0]             cache_write_en_EX,
    input  logic                   cache_read_en_EX,
    input  logic [2:0]             load_type_EX,
    input  logic                   reg_write_en_EX,
    input  logic                   wb_select_EX,
    input  logic [4:0]             reg_dest_EX,
    mem_access_unit_if.master      dc,
    output logic                   stall_mem,
    output logic [31:0]            result_MEM,
    output logic                   reg_write_en_MEM,
    output logic [4:0]             reg_dest_MEM,
    output logic                   mem_err
);

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // EX/MEM stage register
    logic [31:0] alu_q, alu_d;
    logic [31:0] sdata_q, sdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        rd_en_q, rd_en_d;
    logic [2:0]  ltype_q, ltype_d;
    logic        rwe_q, rwe_d;
    logic        wbsel_q, wbsel_d;
    logic [4:0]  rdest_q, rdest_d;

    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        in_req;
    logic        capture;
    logic        mem_op_ex;
    logic [1:0]  off;

    // Align the addressed byte/halfword to bit 0, then extend; bytes past the word read as zero.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  byte_off,
                                                input logic [2:0]  lt);
        logic [31:0] sh;
        sh = word >> {byte_off, 3'b000};
        case (lt)
            3'd1:    extend_load = {{16{sh[15]}}, sh[15:0]};
            3'd2:    extend_load = {16'h0000, sh[15:0]};
            3'd3:    extend_load = {{24{sh[7]}}, sh[7:0]};
            3'd4:    extend_load = {24'h000000, sh[7:0]};
            default: extend_load = sh;
        endcase
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] byte_off,
                                           input logic [3:0] wmask,
                                           input logic       rd,
                                           input logic [2:0] lt);
        logic half_acc;
        logic word_acc;
        half_acc = (wmask == 4'b0011) || (rd && (lt == 3'd1 || lt == 3'd2));
        word_acc = (wmask == 4'b1111) || (rd && (lt == 3'd0 || lt > 3'd4));
        is_misaligned = (half_acc && byte_off[0]) || (word_acc && (byte_off != 2'b00));
    endfunction
`endif

    assign in_req    = (state_q == S_REQ);
    assign capture   = !bubbleM && !in_req;
    assign mem_op_ex = (|cache_write_en_EX) || cache_read_en_EX;
    assign off       = alu_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        sdata_d = sdata_q;
        wmask_d = wmask_q;
        rd_en_d = rd_en_q;
        ltype_d = ltype_q;
        rwe_d   = rwe_q;
        wbsel_d = wbsel_q;
        rdest_d = rdest_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (capture) begin
            alu_d   = ALU_out_EX;
            sdata_d = store_data_EX;
            err_d   = 1'b0;
            if (flushM) begin
                wmask_d = 4'b0000;
                rd_en_d = 1'b0;
                ltype_d = 3'd0;
                rwe_d   = 1'b0;
                wbsel_d = 1'b0;
                rdest_d = 5'd0;
            end else begin
                wmask_d = cache_write_en_EX;
                rd_en_d = cache_read_en_EX;
                ltype_d = load_type_EX;
                rwe_d   = reg_write_en_EX;
                wbsel_d = wb_select_EX;
                rdest_d = reg_dest_EX;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (capture && !flushM && mem_op_ex) begin
`ifdef MEM_MISALIGN_CHECK_EN
                    if (is_misaligned(ALU_out_EX[1:0], cache_write_en_EX,
                                      cache_read_en_EX, load_type_EX)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                // An ack in the timeout cycle still completes the access normally.
                if (dc.dc_ack) begin
                    rdata_d = dc.dc_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alu_q   <= '0;
            sdata_q <= '0;
            wmask_q <= '0;
            rd_en_q <= 1'b0;
            ltype_q <= '0;
            rwe_q   <= 1'b0;
            wbsel_q <= 1'b0;
            rdest_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            sdata_q <= sdata_d;
            wmask_q <= wmask_d;
            rd_en_q <= rd_en_d;
            ltype_q <= ltype_d;
            rwe_q   <= rwe_d;
            wbsel_q <= wbsel_d;
            rdest_q <= rdest_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Lanes shifted past byte 3 fall off the 4-bit mask / 32-bit data.
    always_comb begin
        stall_mem   = in_req;
        dc.dc_req   = in_req;
        dc.dc_addr  = {alu_q[31:2], 2'b00};
        dc.dc_we    = in_req ? (wmask_q << off) : 4'b0000;
        dc.dc_wdata = sdata_q << {off, 3'b000};
        mem_err     = (state_q == S_DONE) && err_q;

        if (err_q) begin
            result_MEM = 32'h0;
        end else if (wbsel_q) begin
            result_MEM = extend_load(rdata_q, off, ltype_q);
        end else begin
            result_MEM = alu_q;
        end
        reg_write_en_MEM = rwe_q && !err_q;
        reg_dest_MEM     = err_q ? 5'd0 : rdest_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stage register, cache handshake, lane shifting,
// load extension, timeout, reset and flush behaviour.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bubbleM, flushM;
    logic [31:0] ALU_out_EX, store_data_EX;
    logic [3:0]  cache_write_en_EX;
    logic        cache_read_en_EX;
    logic [2:0]  load_type_EX;
    logic        reg_write_en_EX, wb_select_EX;
    logic [4:0]  reg_dest_EX;
    logic        stall_mem;
    logic [31:0] result_MEM;
    logic        reg_write_en_MEM;
    logic [4:0]  reg_dest_MEM;
    logic        mem_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req;

    mem_access_unit_if dcif();

    mem_access_unit #(.WAIT_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .bubbleM          (bubbleM),
        .flushM           (flushM),
        .ALU_out_EX       (ALU_out_EX),
        .store_data_EX    (store_data_EX),
        .cache_write_en_EX(cache_write_en_EX),
        .cache_read_en_EX (cache_read_en_EX),
        .load_type_EX     (load_type_EX),
        .reg_write_en_EX  (reg_write_en_EX),
        .wb_select_EX     (wb_select_EX),
        .reg_dest_EX      (reg_dest_EX),
        .dc               (dcif.master),
        .stall_mem        (stall_mem),
        .result_MEM       (result_MEM),
        .reg_write_en_MEM (reg_write_en_MEM),
        .reg_dest_MEM     (reg_dest_MEM),
        .mem_err          (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ALU_out_EX        = 32'h0;
        store_data_EX     = 32'h0;
        cache_write_en_EX = 4'b0000;
        cache_read_en_EX  = 1'b0;
        load_type_EX      = 3'd0;
        reg_write_en_EX   = 1'b0;
        wb_select_EX      = 1'b0;
        reg_dest_EX       = 5'd0;
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] wm,
                          input logic rd, input logic [2:0] lt, input logic rwe,
                          input logic wbs, input logic [4:0] dst);
        ALU_out_EX        = alu;
        store_data_EX     = sd;
        cache_write_en_EX = wm;
        cache_read_en_EX  = rd;
        load_type_EX      = lt;
        reg_write_en_EX   = rwe;
        wb_select_EX      = wbs;
        reg_dest_EX       = dst;
    endtask

    // Issue a load, ack it in the first REQ cycle, and return at the DONE cycle.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] lt,
                           input logic [31:0] rdata, input logic [4:0] dst);
        set_op(addr, 32'h0, 4'b0000, 1'b1, lt, 1'b1, 1'b1, dst);
        tick();
        nop();
        dcif.dc_ack   = 1'b1;
        dcif.dc_rdata = rdata;
        tick();
        dcif.dc_ack   = 1'b0;
    endtask

    initial begin
        bubbleM = 1'b0;
        flushM  = 1'b0;
        dcif.dc_ack   = 1'b0;
        dcif.dc_rdata = 32'h0;
        // Inputs that would be captured if reset did not hold the register.
        set_op(32'h1234_5678, 32'h0, 4'b1111, 1'b0, 3'd0, 1'b1, 1'b0, 5'd3);
        tick();
        tick();
        chk("rst_dc_req",  32'(dcif.dc_req),      32'h0);
        chk("rst_dc_we",   32'(dcif.dc_we),       32'h0);
        chk("rst_stall",   32'(stall_mem),        32'h0);
        chk("rst_mem_err", 32'(mem_err),          32'h0);
        chk("rst_rwe",     32'(reg_write_en_MEM), 32'h0);
        chk("rst_result",  result_MEM,            32'h0);
        nop();
        rst = 1'b0;
        tick();

        // Plain ALU op passes through.
        set_op(32'h1111_2222, 32'h0, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 5'd5);
        tick();
        nop();
        chk("alu_result", result_MEM,            32'h1111_2222);
        chk("alu_rwe",    32'(reg_write_en_MEM), 32'h1);
        chk("alu_rdest",  32'(reg_dest_MEM),     32'd5);
        chk("alu_no_req", 32'(dcif.dc_req),      32'h0);

        // bubbleM holds the stage register.
        bubbleM = 1'b1;
        set_op(32'h9999_9999, 32'h0, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 5'd6);
        tick();
        chk("bubble_hold", result_MEM, 32'h1111_2222);
        bubbleM = 1'b0;
        nop();
        tick();

        // SW 0x104, ack in second REQ cycle.
        set_op(32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        tick();
        nop();
        chk("sw_req",    32'(dcif.dc_req), 32'h1);
        chk("sw_addr",   dcif.dc_addr,     32'h0000_0104);
        chk("sw_we",     32'(dcif.dc_we),  32'hF);
        chk("sw_wdata",  dcif.dc_wdata,    32'hDEAD_BEEF);
        chk("sw_stall1", 32'(stall_mem),   32'h1);
        tick();
        chk("sw_stall2", 32'(stall_mem),   32'h1);
        dcif.dc_ack = 1'b1;
        tick();
        dcif.dc_ack = 1'b0;
        chk("sw_done_stall", 32'(stall_mem),    32'h0);
        chk("sw_done_req",   32'(dcif.dc_req),  32'h0);
        chk("sw_done_err",   32'(mem_err),      32'h0);
        tick();

        // SB 0x01 data 0xAB -> lane 1.
        set_op(32'h0000_0001, 32'h0000_00AB, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        tick();
        nop();
        chk("sb_we",    32'(dcif.dc_we), 32'h2);
        chk("sb_wdata", dcif.dc_wdata,   32'h0000_AB00);
        chk("sb_addr",  dcif.dc_addr,    32'h0000_0000);
        dcif.dc_ack = 1'b1;
        tick();
        dcif.dc_ack = 1'b0;
        chk("sb_err", 32'(mem_err), 32'h0);
        tick();

        // Load extraction.
        do_load(32'h0000_0203, 3'd3, 32'h80FF_0000, 5'd7);
        chk("lb_result", result_MEM,            32'hFFFF_FF80);
        chk("lb_rwe",    32'(reg_write_en_MEM), 32'h1);
        chk("lb_rdest",  32'(reg_dest_MEM),     32'd7);
        tick();
        do_load(32'h0000_0203, 3'd4, 32'h80FF_0000, 5'd7);
        chk("lbu_result", result_MEM, 32'h0000_0080);
        tick();
        do_load(32'h0000_0202, 3'd2, 32'h80FF_0000, 5'd8);
        chk("lhu_result", result_MEM, 32'h0000_80FF);
        tick();
        do_load(32'h0000_0202, 3'd1, 32'h80FF_0000, 5'd8);
        chk("lh_result", result_MEM, 32'hFFFF_80FF);
        tick();
        do_load(32'h0000_0200, 3'd7, 32'h80FF_0000, 5'd8);
        chk("lw_code7_result", result_MEM, 32'h80FF_0000);
        tick();

        // dc_ack outside REQ has no effect.
        dcif.dc_ack = 1'b1;
        tick();
        chk("stray_ack_req", 32'(dcif.dc_req), 32'h0);
        chk("stray_ack_err", 32'(mem_err),     32'h0);
        dcif.dc_ack = 1'b0;

        // Timeout: no ack at all.
        set_op(32'h0000_0300, 32'h0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd10);
        tick();
        nop();
        n_req = 0;
        while (dcif.dc_req === 1'b1 && n_req < 100) begin
            n_req++;
            tick();
        end
        chk("to_req_cycles", 32'(n_req),            32'd64);
        chk("to_mem_err",    32'(mem_err),          32'h1);
        chk("to_rwe",        32'(reg_write_en_MEM), 32'h0);
        chk("to_result",     result_MEM,            32'h0);
        chk("to_stall",      32'(stall_mem),        32'h0);
        tick();
        chk("to_err_pulse",  32'(mem_err),          32'h0);

        // Ack in the 64th REQ cycle wins over the timeout.
        set_op(32'h0000_0300, 32'h0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd11);
        tick();
        nop();
        repeat (63) tick();
        chk("ack64_req", 32'(dcif.dc_req), 32'h1);
        dcif.dc_ack   = 1'b1;
        dcif.dc_rdata = 32'hCAFE_F00D;
        tick();
        dcif.dc_ack   = 1'b0;
        chk("ack64_err",    32'(mem_err),          32'h0);
        chk("ack64_rwe",    32'(reg_write_en_MEM), 32'h1);
        chk("ack64_result", result_MEM,            32'hCAFE_F00D);
        tick();

        // Asynchronous reset in the middle of REQ.
        set_op(32'h0000_0400, 32'h0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd12);
        tick();
        nop();
        chk("rstmid_req_before", 32'(dcif.dc_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req",   32'(dcif.dc_req), 32'h0);
        chk("rstmid_stall", 32'(stall_mem),   32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_idle_req", 32'(dcif.dc_req), 32'h0);
        chk("rstmid_result",   result_MEM,       32'h0);

        // flushM during REQ is ignored; it takes effect on the DONE edge.
        set_op(32'h0000_0400, 32'h0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd9);
        tick();
        flushM = 1'b1;
        tick();
        chk("flush_in_req_stall", 32'(stall_mem), 32'h1);
        dcif.dc_ack   = 1'b1;
        dcif.dc_rdata = 32'h0BAD_F00D;
        tick();
        dcif.dc_ack   = 1'b0;
        chk("flush_done_rwe",    32'(reg_write_en_MEM), 32'h1);
        chk("flush_done_rdest",  32'(reg_dest_MEM),     32'd9);
        chk("flush_done_result", result_MEM,            32'h0BAD_F00D);
        tick();
        chk("flush_after_rwe",   32'(reg_write_en_MEM), 32'h0);
        chk("flush_after_rdest", 32'(reg_dest_MEM),     32'd0);
        chk("flush_after_req",   32'(dcif.dc_req),      32'h0);
        flushM = 1'b0;
        nop();
        tick();

        // Misaligned LW at 0x102.
        set_op(32'h0000_0102, 32'h0, 4'b0000, 1'b1, 3'd0, 1'b1, 1'b1, 5'd13);
        tick();
        nop();
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_lw_req", 32'(dcif.dc_req),      32'h0);
        chk("mis_lw_err", 32'(mem_err),          32'h1);
        chk("mis_lw_rwe", 32'(reg_write_en_MEM), 32'h0);
        tick();
        chk("mis_lw_err_pulse", 32'(mem_err), 32'h0);
`else
        chk("mis_lw_req",  32'(dcif.dc_req), 32'h1);
        chk("mis_lw_addr", dcif.dc_addr,     32'h0000_0100);
        dcif.dc_ack   = 1'b1;
        dcif.dc_rdata = 32'hAABB_CCDD;
        tick();
        dcif.dc_ack   = 1'b0;
        chk("mis_lw_result", result_MEM, 32'h0000_AABB);
        chk("mis_lw_err",    32'(mem_err), 32'h0);
        tick();

        // Misaligned SW at 0x03: only the lowest byte lands in lane 3.
        set_op(32'h0000_0003, 32'h1122_3344, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        tick();
        nop();
        chk("mis_sw_we",    32'(dcif.dc_we), 32'h8);
        chk("mis_sw_wdata", dcif.dc_wdata,   32'h4400_0000);
        dcif.dc_ack = 1'b1;
        tick();
        dcif.dc_ack = 1'b0;
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
